// File: rtl/grid_cursor.sv
// grid_cursor -- button-driven cursor over a ROWS x COLS grid with a two-pick
// selection FSM.
//
// Ports:
//   clk25MHz            sole clock, rising edge
//   rst                 asynchronous active-high reset
//   up/down/right/left  raw push buttons (asynchronous, active-high)
//   sel                 raw select button (asynchronous, active-high)
//   enable              high permits movement and selection
//   clear               synchronous abort of a pending pick
//   cursor              current cell index, row*COLS+col
//   pick1, pick2        last accepted pair of selections
//   pair_valid          one-cycle pulse when a pair completes
//   pending             high while pick1 is held awaiting a second pick
//
// Each button is synchronised (2 flops), debounced (DEBOUNCE stable cycles)
// and edge-detected, so a press reaches the cursor DEBOUNCE+3 edges later.
module grid_cursor #(
  parameter  int ROWS     = 2,
  parameter  int COLS     = 4,
  parameter  int MODE     = 2,
  parameter  int DEBOUNCE = 4,
  localparam int N        = ROWS * COLS,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk25MHz,
  input  logic          rst,
  input  logic          up,
  input  logic          down,
  input  logic          right,
  input  logic          left,
  input  logic          sel,
  input  logic          enable,
  input  logic          clear,
  output logic [IW-1:0] cursor,
  output logic [IW-1:0] pick1,
  output logic [IW-1:0] pick2,
  output logic          pair_valid,
  output logic          pending
);

  // Cursor arithmetic is done one bit wider so +COLS / +N never overflow.
  localparam int XW = IW + 1;
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [XW-1:0] N_X      = XW'(N);
  localparam logic [XW-1:0] COLS_X   = XW'(COLS);
  localparam logic [XW-1:0] ROW_LAST = XW'(ROWS - 1);
  localparam logic [XW-1:0] COL_LAST = XW'(COLS - 1);
  localparam logic [XW-1:0] COL_SPAN = XW'((ROWS - 1) * COLS);

  typedef enum logic {IDLE, HOLD} state_e;

  // Button bit order: 0=up 1=down 2=right 3=left 4=sel (also the priority).
  logic [4:0]    btn_raw;
  logic [4:0]    sync1_q, sync2_q, level_q, prev_q;
  logic [CW-1:0] cnt_q [5];

  assign btn_raw = {sel, left, right, down, up};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others; blocking here would collapse the sync chain.
  // NOTE: the counter array is reset explicitly because a press interrupted by
  // reset must not complete afterwards.
  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= level_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          // DEBOUNCE-th consecutive mismatching cycle: accept the new level.
          level_q[i] <= sync2_q[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Rising edges of the debounced levels, gated by enable (dropped, not queued).
  logic [4:0] act;
  logic       g_up, g_down, g_right, g_left, g_sel;

  assign act     = level_q & ~prev_q & {5{enable}};
  assign g_up    = act[0];
  assign g_down  = act[1] & ~act[0];
  assign g_right = act[2] & ~(|act[1:0]);
  assign g_left  = act[3] & ~(|act[2:0]);
  assign g_sel   = act[4] & ~(|act[3:0]);

  logic [IW-1:0] cursor_q, cursor_d;
  logic [XW-1:0] cur_x, row_x, col_x, nxt_x, down_x;

  assign cur_x  = {1'b0, cursor_q};
  assign row_x  = cur_x / COLS_X;
  assign col_x  = cur_x % COLS_X;
  assign down_x = cur_x + COLS_X;

  // NOTE: nxt_x gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt_x = cur_x;
    case (MODE)
      0: begin
        if (g_up && row_x != '0)            nxt_x = cur_x - COLS_X;
        if (g_down && row_x != ROW_LAST)    nxt_x = cur_x + COLS_X;
        if (g_right && col_x != COL_LAST)   nxt_x = cur_x + XW'(1);
        if (g_left && col_x != '0)          nxt_x = cur_x - XW'(1);
      end
      1: begin
        if (g_up)    nxt_x = (row_x == '0)       ? cur_x + COL_SPAN : cur_x - COLS_X;
        if (g_down)  nxt_x = (row_x == ROW_LAST) ? cur_x - COL_SPAN : cur_x + COLS_X;
        if (g_right) nxt_x = (col_x == COL_LAST) ? cur_x - COL_LAST : cur_x + XW'(1);
        if (g_left)  nxt_x = (col_x == '0)       ? cur_x + COL_LAST : cur_x - XW'(1);
      end
      default: begin
        if (g_up)    nxt_x = (cur_x >= COLS_X) ? cur_x - COLS_X : cur_x + N_X - COLS_X;
        if (g_down)  nxt_x = (down_x >= N_X) ? down_x - N_X : down_x;
        if (g_right) nxt_x = (cur_x == N_X - XW'(1)) ? '0 : cur_x + XW'(1);
        if (g_left)  nxt_x = (cur_x == '0) ? N_X - XW'(1) : cur_x - XW'(1);
      end
    endcase
    cursor_d = IW'(nxt_x);
  end

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) cursor_q <= '0;
    else     cursor_q <= cursor_d;
  end

  // Pick FSM. clear wins over a same-cycle sel and leaves the picks untouched.
  state_e        state_q;
  logic [IW-1:0] pick1_q, pick2_q;
  logic          pair_valid_q;

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pick1_q      <= '0;
      pick2_q      <= '0;
      pair_valid_q <= 1'b0;
    end else begin
      pair_valid_q <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
      end else if (g_sel) begin
        case (state_q)
          IDLE: begin
            pick1_q <= cursor_q;
            state_q <= HOLD;
          end
          HOLD: begin
            // Picking the same cell twice is not a pair; keep waiting.
            if (cursor_q != pick1_q) begin
              pick2_q      <= cursor_q;
              pair_valid_q <= 1'b1;
              state_q      <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cursor     = cursor_q;
  assign pick1      = pick1_q;
  assign pick2      = pick2_q;
  assign pair_valid = pair_valid_q;
  assign pending    = (state_q == HOLD);

endmodule

// File: tb/tb_grid_cursor.sv
// Directed bench for grid_cursor (ROWS=2, COLS=4, DEBOUNCE=4). Three instances
// share all inputs: MODE 0 (clamp), MODE 1 (toroidal) and MODE 2 (linear);
// the MODE 2 instance also carries the pick checks.
module tb_grid_cursor;

  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  localparam logic [4:0] B_UP    = 5'b00001;
  localparam logic [4:0] B_DOWN  = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b01000;
  localparam logic [4:0] B_SEL   = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic       enable;
  logic       clear;

  logic [2:0] c0, c1, c2;
  logic [2:0] p1_0, p2_0, p1_1, p2_1, p1_2, p2_2;
  logic       pv0, pv1, pv2, pd0, pd1, pd2;

  int n_cmp = 0;
  int n_bad = 0;

  always #20 clk = ~clk;

  grid_cursor #(.ROWS(2), .COLS(4), .MODE(0), .DEBOUNCE(DB)) u_m0 (
    .clk25MHz(clk), .rst(rst),
    .up(btn[0]), .down(btn[1]), .right(btn[2]), .left(btn[3]), .sel(btn[4]),
    .enable(enable), .clear(clear),
    .cursor(c0), .pick1(p1_0), .pick2(p2_0), .pair_valid(pv0), .pending(pd0)
  );

  grid_cursor #(.ROWS(2), .COLS(4), .MODE(1), .DEBOUNCE(DB)) u_m1 (
    .clk25MHz(clk), .rst(rst),
    .up(btn[0]), .down(btn[1]), .right(btn[2]), .left(btn[3]), .sel(btn[4]),
    .enable(enable), .clear(clear),
    .cursor(c1), .pick1(p1_1), .pick2(p2_1), .pair_valid(pv1), .pending(pd1)
  );

  grid_cursor #(.ROWS(2), .COLS(4), .MODE(2), .DEBOUNCE(DB)) u_m2 (
    .clk25MHz(clk), .rst(rst),
    .up(btn[0]), .down(btn[1]), .right(btn[2]), .left(btn[3]), .sel(btn[4]),
    .enable(enable), .clear(clear),
    .cursor(c2), .pick1(p1_2), .pick2(p2_2), .pair_valid(pv2), .pending(pd2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cur(input string tag, input int e0, input int e1, input int e2);
    check({tag, "_m0"}, 32'(c0), 32'(e0));
    check({tag, "_m1"}, 32'(c1), 32'(e1));
    check({tag, "_m2"}, 32'(c2), 32'(e2));
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a button pattern until it has acted, release, wait for levels to fall.
  task automatic press(input logic [4:0] mask);
    btn = mask;
    step(LAT);
    btn = '0;
    step(LAT + 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #5;
    rst = 1'b0;
    step(2);
  endtask

  initial begin
    rst    = 1'b1;
    btn    = '0;
    enable = 1'b1;
    clear  = 1'b0;
    step(3);
    check_cur("rst_cursor", 0, 0, 0);
    check("rst_pick1", 32'(p1_2), 0);
    check("rst_pick2", 32'(p2_2), 0);
    check("rst_pair_valid", 32'(pv2), 0);
    check("rst_pending", 32'(pd2), 0);
    rst = 1'b0;
    step(2);

    // Latency: right held 20 cycles, moves exactly once, 7 edges after press.
    btn = B_RIGHT;
    step(LAT - 1);
    check("lat_before", 32'(c2), 0);
    step(1);
    check("lat_at", 32'(c2), 1);
    step(20 - LAT);
    check_cur("lat_single", 1, 1, 1);
    btn = '0;
    step(LAT + 1);

    // Priority: up+right together at 1; up wins, right dropped.
    press(B_UP | B_RIGHT);
    check_cur("prio_up_right", 1, 5, 5);

    // Left/up edges from 0.
    do_reset();
    press(B_LEFT);
    check_cur("left_at_0", 0, 3, 7);
    press(B_UP);
    check_cur("up_edge", 0, 7, 3);

    // Right edge at column 3.
    do_reset();
    press(B_RIGHT);
    press(B_RIGHT);
    press(B_RIGHT);
    check_cur("walk_to_3", 3, 3, 3);
    press(B_RIGHT);
    check_cur("right_at_3", 3, 0, 4);

    // Down at 5.
    do_reset();
    press(B_RIGHT);
    press(B_DOWN);
    check_cur("down_to_5", 5, 5, 5);
    press(B_DOWN);
    check_cur("down_at_5", 5, 1, 1);

    // Down at 6.
    do_reset();
    press(B_RIGHT);
    press(B_RIGHT);
    press(B_DOWN);
    check_cur("down_to_6", 6, 6, 6);
    press(B_DOWN);
    check_cur("down_at_6", 6, 2, 2);

    // Debounce: 3 synchronised high cycles are rejected, 4 are accepted.
    btn = B_RIGHT;
    step(3);
    btn = '0;
    step(12);
    check_cur("bounce_3", 6, 2, 2);
    btn = B_RIGHT;
    step(4);
    btn = '0;
    step(12);
    check_cur("bounce_4", 7, 3, 3);

    // Enable gating: press with enable low, still held when enable rises.
    enable = 1'b0;
    btn    = B_RIGHT;
    step(LAT + 2);
    check("en_low", 32'(c2), 3);
    enable = 1'b1;
    step(10);
    check("en_rise_held", 32'(c2), 3);
    btn = '0;
    step(LAT + 1);
    check("en_release", 32'(c2), 3);

    // Pick pair: sel at 2, move to 6, sel.
    do_reset();
    press(B_RIGHT);
    press(B_RIGHT);
    press(B_SEL);
    check("pick1_first", 32'(p1_2), 2);
    check("pend_first", 32'(pd2), 1);
    press(B_DOWN);
    check("move_to_6", 32'(c2), 6);
    btn = B_SEL;
    step(LAT - 1);
    check("pv_before", 32'(pv2), 0);
    check("pend_before", 32'(pd2), 1);
    step(1);
    check("pv_pulse", 32'(pv2), 1);
    check("pair_pick1", 32'(p1_2), 2);
    check("pair_pick2", 32'(p2_2), 6);
    check("pend_after_pair", 32'(pd2), 0);
    step(1);
    check("pv_one_cycle", 32'(pv2), 0);
    btn = '0;
    step(LAT + 1);

    // Same cell twice: second sel ignored.
    press(B_UP);
    check("back_to_2", 32'(c2), 2);
    press(B_SEL);
    check("same_pend1", 32'(pd2), 1);
    btn = B_SEL;
    step(LAT);
    check("same_pv", 32'(pv2), 0);
    check("same_pend2", 32'(pd2), 1);
    check("same_pick2", 32'(p2_2), 6);
    btn = '0;
    step(LAT + 1);
    check("same_pend3", 32'(pd2), 1);

    // clear and sel in the same cycle while in HOLD.
    press(B_RIGHT);
    btn = B_SEL;
    step(LAT - 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_pend", 32'(pd2), 0);
    check("clr_pv", 32'(pv2), 0);
    check("clr_pick2", 32'(p2_2), 6);
    check("clr_cursor", 32'(c2), 3);
    btn = '0;
    step(LAT + 1);
    check("clr_idle", 32'(pd2), 0);
    press(B_SEL);
    check("post_clr_pick1", 32'(p1_2), 3);
    check("post_clr_pend", 32'(pd2), 1);

    // Reset mid-debounce while in HOLD: immediate clear, nothing afterwards.
    btn = B_RIGHT;
    step(4);
    rst = 1'b1;
    #1;
    check_cur("arst_cursor", 0, 0, 0);
    check("arst_pick1", 32'(p1_2), 0);
    check("arst_pick2", 32'(p2_2), 0);
    check("arst_pend", 32'(pd2), 0);
    check("arst_pv", 32'(pv2), 0);
    btn = '0;
    #5;
    rst = 1'b0;
    step(20);
    check("arst_no_move", 32'(c2), 0);
    check("arst_idle", 32'(pd2), 0);
    press(B_SEL);
    check("arst_sel_pend", 32'(pd2), 1);
    check("arst_sel_pick1", 32'(p1_2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
